tlul_txn_tracker: RTL and testbench

- Passive, parametrised TL-UL transaction tracker for DV benches and debug builds.
- Observes A-channel request and D-channel response handshakes.
- Tracks in-flight source IDs and flags protocol errors: duplicate source, unexpected response, outstanding overflow, response timeout.
- Exposes live and cumulative counters. Never drives the bus; sits beside a TL host or device port.

---
 rtl/tlul_txn_tracker.sv | 145 ++++++++++++++
 tb/tb_tlul_txn_tracker.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tlul_txn_tracker.sv
// Passive TL-UL transaction tracker: follows in-flight source IDs across A/D handshakes
// and raises sticky protocol-error flags plus live/cumulative counters.

module tlul_txn_entry #(
  parameter int TimeoutCycles = 1024,
  parameter int AgeW          = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic alloc,
  input  logic retire,
  output logic pending,
  output logic tmo_hit
);
  logic [AgeW-1:0] age;
  logic            tmo;

  // A retiring entry never reports a timeout in the same cycle.
  assign tmo_hit = pending & ~tmo & (age == AgeW'(TimeoutCycles)) & ~retire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
      age     <= '0;
      tmo     <= 1'b0;
    end else if (clr) begin
      pending <= 1'b0;
      age     <= '0;
      tmo     <= 1'b0;
    end else if (alloc | retire) begin
      pending <= alloc;
      age     <= '0;
      tmo     <= 1'b0;
    end else if (pending) begin
      if (age != AgeW'(TimeoutCycles)) age <= age + AgeW'(1);
      if (tmo_hit) tmo <= 1'b1;
    end
  end
endmodule

module tlul_txn_tracker #(
  parameter int SrcW           = 8,
  parameter int MaxOutstanding = 16,
  parameter int TimeoutCycles  = 1024,
  parameter int CntW           = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clr,
  input  logic                                  a_valid,
  input  logic                                  a_ready,
  input  logic [SrcW-1:0]                       a_source,
  input  logic                                  d_valid,
  input  logic                                  d_ready,
  input  logic [SrcW-1:0]                       d_source,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding,
  output logic [CntW-1:0]                       req_cnt,
  output logic [CntW-1:0]                       rsp_cnt,
  output logic                                  err_dup,
  output logic                                  err_unexp,
  output logic                                  err_ovf,
  output logic                                  err_tmo,
  output logic [SrcW-1:0]                       err_src,
  output logic                                  err_any
);
  localparam int Entries = 1 << SrcW;
  localparam int OutW    = $clog2(MaxOutstanding+1);
  localparam int AgeW    = $clog2(TimeoutCycles+1);

  logic               a_fire, d_fire, rsp_hit, full, alloc;
  logic               unexp_ev, dup_ev, ovf_ev, tmo_ev, new_err;
  logic [Entries-1:0] pend_v, tmo_v, alloc_v, retire_v;
  logic [SrcW-1:0]    tmo_src, src_sel;

  assign a_fire   = a_valid & a_ready;
  assign d_fire   = d_valid & d_ready;
  assign full     = (outstanding == OutW'(MaxOutstanding));
  assign rsp_hit  = d_fire & pend_v[d_source];
  assign unexp_ev = d_fire & ~pend_v[d_source];
  // A pending source may be reissued only in the cycle its response retires it.
  assign dup_ev   = a_fire & pend_v[a_source] & ~(rsp_hit & (d_source == a_source));
  assign ovf_ev   = a_fire & ~pend_v[a_source] & full & ~rsp_hit;
  assign alloc    = a_fire & ~dup_ev & ~ovf_ev;
  assign alloc_v  = alloc   ? (Entries'(1) << a_source) : '0;
  assign retire_v = rsp_hit ? (Entries'(1) << d_source) : '0;
  assign tmo_ev   = |tmo_v;
  assign new_err  = unexp_ev | dup_ev | ovf_ev | tmo_ev;

  for (genvar i = 0; i < Entries; i++) begin : g_ent
    tlul_txn_entry #(.TimeoutCycles(TimeoutCycles), .AgeW(AgeW)) u_ent (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .alloc  (alloc_v[i]),
      .retire (retire_v[i]),
      .pending(pend_v[i]),
      .tmo_hit(tmo_v[i])
    );
  end

  always_comb begin
    tmo_src = '0;
    for (int i = Entries-1; i >= 0; i--)
      if (tmo_v[i]) tmo_src = SrcW'(i);
    if (unexp_ev)    src_sel = d_source;
    else if (dup_ev) src_sel = a_source;
    else if (ovf_ev) src_sel = a_source;
    else             src_sel = tmo_src;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      req_cnt     <= '0;
      rsp_cnt     <= '0;
      err_dup     <= 1'b0;
      err_unexp   <= 1'b0;
      err_ovf     <= 1'b0;
      err_tmo     <= 1'b0;
      err_src     <= '0;
      err_any     <= 1'b0;
    end else if (clr) begin
      outstanding <= '0;
      req_cnt     <= '0;
      rsp_cnt     <= '0;
      err_dup     <= 1'b0;
      err_unexp   <= 1'b0;
      err_ovf     <= 1'b0;
      err_tmo     <= 1'b0;
      err_src     <= '0;
      err_any     <= 1'b0;
    end else begin
      outstanding <= outstanding + OutW'(alloc) - OutW'(rsp_hit);
      if (alloc && (req_cnt != '1))   req_cnt <= req_cnt + CntW'(1);
      if (rsp_hit && (rsp_cnt != '1)) rsp_cnt <= rsp_cnt + CntW'(1);
      err_dup   <= err_dup   | dup_ev;
      err_unexp <= err_unexp | unexp_ev;
      err_ovf   <= err_ovf   | ovf_ev;
      err_tmo   <= err_tmo   | tmo_ev;
      err_any   <= err_any   | new_err;
      if (!err_any && new_err) err_src <= src_sel;
    end
  end
endmodule

// File: tb/tb_tlul_txn_tracker.sv
// Bench for tlul_txn_tracker: directed plan with literal expectations, then random
// traffic checked every cycle against a table-level reference model.

module tb_tlul_txn_tracker;
  localparam int SrcW = 2, MaxO = 3, Tmo = 8, CntW = 4;
  localparam int N = 1 << SrcW;
  localparam int CntMax = (1 << CntW) - 1;

  logic clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic a_valid = 0, a_ready = 0, d_valid = 0, d_ready = 0;
  logic [SrcW-1:0] a_source = '0, d_source = '0;
  logic [1:0] outstanding;
  logic [CntW-1:0] req_cnt, rsp_cnt;
  logic err_dup, err_unexp, err_ovf, err_tmo, err_any;
  logic [SrcW-1:0] err_src;

  tlul_txn_tracker #(.SrcW(SrcW), .MaxOutstanding(MaxO), .TimeoutCycles(Tmo), .CntW(CntW)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .a_valid(a_valid), .a_ready(a_ready), .a_source(a_source),
    .d_valid(d_valid), .d_ready(d_ready), .d_source(d_source),
    .outstanding(outstanding), .req_cnt(req_cnt), .rsp_cnt(rsp_cnt),
    .err_dup(err_dup), .err_unexp(err_unexp), .err_ovf(err_ovf), .err_tmo(err_tmo),
    .err_src(err_src), .err_any(err_any));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit chk_en = 0;

  // Reference model: which sources are in flight, how long each has waited.
  bit m_pend[N];
  int m_age[N];
  bit m_flag[N];
  int m_req, m_rsp, m_src;
  bit m_dup, m_unexp, m_ovf, m_tmo;

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_age[i] = 0; m_flag[i] = 0; end
    m_req = 0; m_rsp = 0; m_src = 0;
    m_dup = 0; m_unexp = 0; m_ovf = 0; m_tmo = 0;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  function automatic void m_step(bit af, int as, bit df, int ds, bit c);
    bit hit, unexp, dup, ovf, al;
    bit timed[N];
    int first_t;
    bit was_err;
    if (c) begin m_clear(); return; end
    hit = df && m_pend[ds];
    unexp = df && !m_pend[ds];
    dup = 0; ovf = 0; al = 0;
    first_t = -1;
    for (int i = 0; i < N; i++) begin
      timed[i] = m_pend[i] && !m_flag[i] && m_age[i] >= Tmo && !(hit && ds == i);
      if (timed[i] && first_t < 0) first_t = i;
    end
    if (af) begin
      if (m_pend[as] && !(hit && ds == as)) dup = 1;
      else if (m_count() == MaxO && !hit)   ovf = 1;
      else                                  al = 1;
    end
    for (int i = 0; i < N; i++) begin
      if ((hit && ds == i) || (al && as == i)) begin
        m_pend[i] = al && as == i; m_age[i] = 0; m_flag[i] = 0;
      end else if (m_pend[i]) begin
        if (m_age[i] < Tmo) m_age[i]++;
        if (timed[i]) m_flag[i] = 1;
      end
    end
    if (al && m_req < CntMax) m_req++;
    if (hit && m_rsp < CntMax) m_rsp++;
    was_err = m_dup | m_unexp | m_ovf | m_tmo;
    if (!was_err && (unexp | dup | ovf | (first_t >= 0)))
      m_src = unexp ? ds : (dup || ovf) ? as : first_t;
    m_dup |= dup; m_unexp |= unexp; m_ovf |= ovf; m_tmo |= (first_t >= 0);
  endfunction

  always @(negedge clk) if (chk_en && !rst) begin
    chk("outstanding", int'(outstanding), m_count());
    chk("req_cnt", int'(req_cnt), m_req);
    chk("rsp_cnt", int'(rsp_cnt), m_rsp);
    chk("err_dup", int'(err_dup), int'(m_dup));
    chk("err_unexp", int'(err_unexp), int'(m_unexp));
    chk("err_ovf", int'(err_ovf), int'(m_ovf));
    chk("err_tmo", int'(err_tmo), int'(m_tmo));
    chk("err_any", int'(err_any), int'(m_dup | m_unexp | m_ovf | m_tmo));
    chk("err_src", int'(err_src), m_src);
  end

  task automatic cyc(bit av, bit ar, int as, bit dv, bit dr, int ds, bit c);
    a_valid = av; a_ready = ar; a_source = SrcW'(as);
    d_valid = dv; d_ready = dr; d_source = SrcW'(ds);
    clr = c;
    @(posedge clk);
    m_step(av & ar, as, dv & dr, ds, c);
    @(negedge clk);
  endtask

  task automatic req(int s);          cyc(1, 1, s, 0, 0, 0, 0); endtask
  task automatic rsp(int s);          cyc(0, 0, 0, 1, 1, s, 0); endtask
  task automatic both(int a, int d);  cyc(1, 1, a, 1, 1, d, 0); endtask
  task automatic idle();              cyc(0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_clr();            cyc(0, 0, 0, 0, 0, 0, 1); endtask

  function automatic void chk_zero(string nm);
    chk({nm, "_out"}, int'(outstanding), 0);
    chk({nm, "_req"}, int'(req_cnt), 0);
    chk({nm, "_rsp"}, int'(rsp_cnt), 0);
    chk({nm, "_errs"}, int'({err_dup, err_unexp, err_ovf, err_tmo, err_any}), 0);
    chk({nm, "_src"}, int'(err_src), 0);
  endfunction

  initial begin
    int pd;
    m_clear();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    chk_en = 1;

    // 1: three requests then out-of-order responses
    req(0); chk("t1_o1", int'(outstanding), 1);
    req(1); chk("t1_o2", int'(outstanding), 2);
    req(2); chk("t1_o3", int'(outstanding), 3);
    rsp(2); chk("t1_o4", int'(outstanding), 2);
    rsp(0); chk("t1_o5", int'(outstanding), 1);
    rsp(1); chk("t1_o6", int'(outstanding), 0);
    chk("t1_req", int'(req_cnt), 3); chk("t1_rsp", int'(rsp_cnt), 3);
    chk("t1_any", int'(err_any), 0);

    // 2: overflow, then retire+allocate in one cycle
    do_clr(); req(0); req(1); req(2); req(3);
    chk("t2_ovf", int'(err_ovf), 1); chk("t2_src", int'(err_src), 3);
    chk("t2_out", int'(outstanding), 3);
    both(3, 0);
    chk("t2_out2", int'(outstanding), 3); chk("t2_req", int'(req_cnt), 4);
    chk("t2_dup", int'(err_dup), 0); chk("t2_src2", int'(err_src), 3);

    // 3: duplicate source, then legal same-cycle reuse
    do_clr(); req(1); req(1);
    chk("t3_dup", int'(err_dup), 1); chk("t3_src", int'(err_src), 1);
    chk("t3_req", int'(req_cnt), 1);
    do_clr(); req(1); both(1, 1);
    chk("t3_any", int'(err_any), 0); chk("t3_out", int'(outstanding), 1);
    chk("t3_req2", int'(req_cnt), 2); chk("t3_rsp2", int'(rsp_cnt), 1);

    // 4: unexpected response, including zero-latency response
    do_clr(); rsp(2);
    chk("t4_unexp", int'(err_unexp), 1); chk("t4_src", int'(err_src), 2);
    chk("t4_rsp", int'(rsp_cnt), 0);
    do_clr(); both(2, 2);
    chk("t4_unexp2", int'(err_unexp), 1); chk("t4_out", int'(outstanding), 1);

    // 5: timeout exactly at age Tmo
    do_clr(); req(0);
    for (int k = 1; k <= Tmo; k++) begin idle(); chk("t5_early", int'(err_tmo), 0); end
    idle(); chk("t5_tmo", int'(err_tmo), 1); chk("t5_src", int'(err_src), 0);
    rsp(0);
    chk("t5_out", int'(outstanding), 0); chk("t5_rsp", int'(rsp_cnt), 1);
    chk("t5_sticky", int'(err_tmo), 1);

    // 6: clr beats a same-cycle request; async reset mid-traffic
    do_clr(); req(0); req(1); rsp(3);
    cyc(1, 1, 2, 0, 0, 0, 1);
    chk_zero("t6_clr");
    req(0); req(1);
    a_valid = 1; a_ready = 1; a_source = 2;
    #2 rst = 1'b1; m_clear();
    #1 chk_zero("t6_rst");
    @(negedge clk); rst = 1'b0;

    // random traffic with alternating response pressure
    for (int seg = 0; seg < 8; seg++) begin
      pd = (seg % 2 == 0) ? 70 : 8;
      for (int k = 0; k < 400; k++)
        cyc($urandom_range(99) < 50, $urandom_range(99) < 80, $urandom_range(N-1),
            $urandom_range(99) < pd, $urandom_range(99) < 85, $urandom_range(N-1),
            $urandom_range(299) == 0);
      if (seg == 3) do_clr();
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
